// File: rtl/psk_pkg.sv
// psk_pkg -- shared constants and types for the 2PSK modulator/demodulator chain.
//
// Contents:
//   SYM_LEN_DEF  default samples per symbol (even, >= 2, power of two)
//   AMB_W_DEF    default width of the ambiguity (tie) counter
//   ph_w()       width of the in-symbol phase counter for a given SYM_LEN
//   cnt_w()      width of the match accumulator; holds the value SYM_LEN
//   psk_state_t  demodulator mode: IDLE (start low) or RUN (start high)
package psk_pkg;

  localparam int SYM_LEN_DEF = 4;
  localparam int AMB_W_DEF   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } psk_state_t;

  function automatic int ph_w(input int sym_len);
    return $clog2(sym_len);
  endfunction

  // One extra bit so a full-symbol total of SYM_LEN matches never wraps.
  function automatic int cnt_w(input int sym_len);
    return $clog2(sym_len) + 1;
  endfunction

endpackage

// File: rtl/psk_carrier_gen.sv
// psk_carrier_gen -- symbol phase counter and 0-degree reference carrier.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    run enable; low holds the phase at 0 (flush)
//   phase_o    sample index inside the current symbol, 0..SYM_LEN-1
//   ref_o      reference carrier: 1 for the first half of the symbol, else 0
//   sym_end_o  high on the last sample of a symbol while running
//   state_o    registered mode (mode of the previous cycle), for debug
//
// The mode this cycle follows start_i directly: the first cycle with
// start_i high is already sample 0, so sampling decisions use state_d.
module psk_carrier_gen
  import psk_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic [ph_w(SYM_LEN)-1:0]   phase_o,
  output logic                       ref_o,
  output logic                       sym_end_o,
  output psk_state_t                 state_o
);

  localparam int PH_W = ph_w(SYM_LEN);
  localparam logic [PH_W-1:0] LAST = PH_W'(SYM_LEN - 1);
  localparam logic [PH_W-1:0] HALF = PH_W'(SYM_LEN / 2);

  psk_state_t      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            run;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = start_i ? RUN : IDLE;
  end

  // Outputs and phase advance
  always_comb begin
    run       = (state_d == RUN);
    sym_end_o = run && (phase_q == LAST);
    ref_o     = (phase_q < HALF);
    phase_o   = phase_q;
    state_o   = state_q;
    phase_d   = '0;
    if (run && (phase_q != LAST)) begin
      phase_d = phase_q + PH_W'(1);
    end
  end

endmodule

// File: rtl/psk_coherent_demod.sv
// psk_coherent_demod -- coherent 2PSK demodulator producing relative-code bits.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (priority over start)
//   start      demodulation enable; low = idle and discard partial symbol
//   psk_in     1-bit received PSK sample, one per clock
//   rel_out    decided relative-code bit, held between decisions
//   bit_valid  one-cycle strobe, high in the cycle rel_out was updated
//   amb_cnt    number of tie decisions (saturating)
//
// Each sample is compared with the local reference; the number of agreeing
// samples over a symbol picks in-phase (0) or antiphase (1). A tie keeps the
// previous bit but still strobes so the downstream decoder stays aligned.
//
// Build option: define PSK_DEMOD_AMBCNT_EN to count tie decisions in amb_cnt;
// otherwise amb_cnt is constant 0 and no counter is built.
module psk_coherent_demod
  import psk_pkg::*;
#(
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int AMB_W   = AMB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             psk_in,
  output logic             rel_out,
  output logic             bit_valid,
  output logic [AMB_W-1:0] amb_cnt
);

  localparam int CNT_W = cnt_w(SYM_LEN);
  localparam int PH_W  = ph_w(SYM_LEN);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(SYM_LEN / 2);

  logic [PH_W-1:0]  phase;
  logic             ref_bit;
  logic             sym_end;
  psk_state_t       state_unused;

  logic             match;
  logic [CNT_W-1:0] tot;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             rel_q, rel_d;
  logic             valid_q, valid_d;

  psk_carrier_gen #(
    .SYM_LEN (SYM_LEN)
  ) u_carrier (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .phase_o   (phase),
    .ref_o     (ref_bit),
    .sym_end_o (sym_end),
    .state_o   (state_unused)
  );

  assign match = ~(psk_in ^ ref_bit);
  // Restart the sum on sample 0 so a stale accumulator can never leak
  // into a new symbol.
  assign tot   = ((phase == '0) ? '0 : acc_q) + CNT_W'(match);

  always_comb begin
    acc_d   = acc_q;
    rel_d   = rel_q;
    valid_d = 1'b0;
    if (!start) begin
      acc_d = '0;
    end else if (sym_end) begin
      acc_d   = '0;
      valid_d = 1'b1;
      if (tot > HALF) begin
        rel_d = 1'b0;
      end else if (tot < HALF) begin
        rel_d = 1'b1;
      end
    end else begin
      acc_d = tot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      rel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
    end
  end

  assign rel_out   = rel_q;
  assign bit_valid = valid_q;

`ifdef PSK_DEMOD_AMBCNT_EN
  logic [AMB_W-1:0] amb_q, amb_d;
  logic             tie;

  assign tie = start && sym_end && (tot == HALF);

  always_comb begin
    amb_d = amb_q;
    if (tie && (amb_q != {AMB_W{1'b1}})) begin
      amb_d = amb_q + AMB_W'(1);
    end
  end

  // Cleared by reset only; idling does not lose the tie history.
  always_ff @(posedge clk) begin
    if (rst) begin
      amb_q <= '0;
    end else begin
      amb_q <= amb_d;
    end
  end

  assign amb_cnt = amb_q;
`else
  assign amb_cnt = '0;
`endif

endmodule
